// File: rtl/clk_div_pkg.sv
// Shared definitions for the sequenced clock divider: FSM encoding and
// default parameter values for ratio width and reset ratio.
package clk_div_pkg;

    localparam int unsigned DEF_W       = 8;
    localparam int unsigned DEF_RST_DIV = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StPend = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Period counter and waveform generator: produces the registered divided clock,
// the period-start tick and the period boundary flag for the ratio in force.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         run,
    input  logic [W-1:0] div_active,
    output logic         clk_out,
    output logic         period_tick,
    output logic         boundary
);

    logic         run_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;
    logic [W:0]   cnt_inc;
    logic [W:0]   high;

    // One extra bit so (N+1)/2 cannot overflow at N = 2^W-1.
    assign cnt_inc  = {1'b0, cnt_q} + (W+1)'(1);
    assign high     = ({1'b0, div_active} + (W+1)'(1)) >> 1;
    assign boundary = run_q && (cnt_q == div_active - W'(1));

    always_comb begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        tick_d = 1'b0;
        if (run) begin
            if (!run_q || boundary) begin
                // cnt restarts at 0, which is always inside the high phase
                clk_d  = 1'b1;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_inc[W-1:0];
                clk_d = (cnt_inc < high);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            run_q  <= run;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out     = clk_q;
    assign period_tick = tick_q;

endmodule

// File: rtl/clk_div_seq.sv
// Clock divider with ratio handshake: new ratios are held pending and only
// committed on a period boundary so no output period mixes two ratios.
module clk_div_seq
    import clk_div_pkg::*;
#(
    parameter int unsigned W       = DEF_W,
    parameter int unsigned RST_DIV = DEF_RST_DIV
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_val,
    input  logic         div_valid,
    output logic         div_ready,
    output logic         clk_out,
    output logic         period_tick,
    output logic [W-1:0] div_active,
    output logic         div_err,
    output logic         busy
);

    state_e       state_q, state_d;
    logic [W-1:0] active_q, active_d;
    logic [W-1:0] pend_q, pend_d;
    logic         err_q, err_d;
    logic         boundary;
    logic         xfer;
    logic         ratio_ok;
    logic         run;

    assign xfer     = div_valid && div_ready;
    assign ratio_ok = (div_val >= W'(2));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        err_d    = xfer && !ratio_ok;
        unique case (state_q)
            StIdle: begin
                if (xfer && ratio_ok) begin
                    active_d = div_val;
                end
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Stopping: there is no following period, so commit directly.
                if (boundary && !en) begin
                    state_d = StIdle;
                    if (xfer && ratio_ok) begin
                        active_d = div_val;
                    end
                end else if (xfer && ratio_ok) begin
                    pend_d  = div_val;
                    state_d = StPend;
                end
            end
            StPend: begin
                if (boundary) begin
                    active_d = pend_q;
                    pend_d   = '0;
                    state_d  = en ? StRun : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_ready = (state_q != StPend);
        busy      = (state_q != StIdle);
        run       = (state_d != StIdle);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            active_q <= W'(RST_DIV);
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign div_active = active_q;
    assign div_err    = err_q;

    clk_div_core #(
        .W (W)
    ) u_core (
        .clk_in      (clk_in),
        .rst         (rst),
        .run         (run),
        .div_active  (active_q),
        .clk_out     (clk_out),
        .period_tick (period_tick),
        .boundary    (boundary)
    );

endmodule

// File: tb/tb_clk_div_seq.sv
// Bench for clk_div_seq: directed vector table, async-reset sequence and
// randomized traffic checked against a period-position reference model.
module tb_clk_div_seq;

    localparam int unsigned W       = 8;
    localparam int unsigned RST_DIV = 3;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] div_val = '0;
    logic         div_valid = 1'b0;
    logic         div_ready;
    logic         clk_out;
    logic         period_tick;
    logic [W-1:0] div_active;
    logic         div_err;
    logic         busy;

    always #10 clk_in = ~clk_in;

    clk_div_seq #(
        .W       (W),
        .RST_DIV (RST_DIV)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .div_val     (div_val),
        .div_valid   (div_valid),
        .div_ready   (div_ready),
        .clk_out     (clk_out),
        .period_tick (period_tick),
        .div_active  (div_active),
        .div_err     (div_err),
        .busy        (busy)
    );

    typedef struct packed {
        logic         clk;
        logic         tick;
        logic         rdy;
        logic         bsy;
        logic [W-1:0] act;
        logic         err;
    } obs_t;

    typedef struct {
        logic         en;
        logic         valid;
        logic [W-1:0] val;
        obs_t         exp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position within the current period, ratio in force,
    // queue of waiting ratios.
    bit m_run;
    int m_pos;
    int m_n;
    bit m_err;
    int m_pend[$];

    function automatic obs_t mk_obs(input logic c, input logic t, input logic r,
                                    input logic b, input int a, input logic e);
        obs_t o;
        o.clk  = c;
        o.tick = t;
        o.rdy  = r;
        o.bsy  = b;
        o.act  = W'(a);
        o.err  = e;
        return o;
    endfunction

    function automatic vec_t mk(input logic e, input logic v, input int val, input logic c,
                                input logic t, input logic r, input logic b, input int a,
                                input logic er);
        vec_t x;
        x.en    = e;
        x.valid = v;
        x.val   = W'(val);
        x.exp   = mk_obs(c, t, r, b, a, er);
        return x;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = mk_obs(clk_out, period_tick, div_ready, busy, int'(div_active), div_err);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got clk=%b tick=%b rdy=%b busy=%b act=%0d err=%b, want clk=%b tick=%b rdy=%b busy=%b act=%0d err=%b",
                     name, act.clk, act.tick, act.rdy, act.bsy, act.act, act.err,
                     exp.clk, exp.tick, exp.rdy, exp.bsy, exp.act, exp.err);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        m_n   = RST_DIV;
        m_err = 1'b0;
        m_pend.delete();
    endtask

    task automatic model_step(input logic e, input logic v, input int val);
        bit xfer;
        bit ok;
        xfer  = v && (m_pend.size() == 0);
        ok    = (val >= 2);
        m_err = xfer && !ok;
        if (!m_run) begin
            if (xfer && ok) m_n = val;
            if (e) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == m_n - 1) begin
            if (m_pend.size() > 0) m_n = m_pend.pop_front();
            m_pos = 0;
            if (!e) begin
                m_run = 1'b0;
                if (xfer && ok) m_n = val;
            end else if (xfer && ok) begin
                m_pend.push_back(val);
            end
        end else begin
            m_pos++;
            if (xfer && ok) m_pend.push_back(val);
        end
    endtask

    function automatic obs_t model_obs();
        return mk_obs(m_run && (m_pos < (m_n + 1) / 2), m_run && (m_pos == 0),
                      m_pend.size() == 0, m_run, m_n, m_err);
    endfunction

    vec_t table_v[27];

    initial begin
        // en, valid, val | clk, tick, rdy, busy, act, err  (outputs after the edge)
        table_v[0]  = mk(1, 0, 0, 1, 1, 1, 1, 3, 0);
        table_v[1]  = mk(1, 0, 0, 1, 0, 1, 1, 3, 0);
        table_v[2]  = mk(1, 0, 0, 0, 0, 1, 1, 3, 0);
        table_v[3]  = mk(1, 0, 0, 1, 1, 1, 1, 3, 0);
        table_v[4]  = mk(1, 0, 0, 1, 0, 1, 1, 3, 0);
        table_v[5]  = mk(1, 1, 4, 0, 0, 0, 1, 3, 0);  // N=4 sent at cnt=1
        table_v[6]  = mk(1, 0, 0, 1, 1, 1, 1, 4, 0);
        table_v[7]  = mk(1, 0, 0, 1, 0, 1, 1, 4, 0);
        table_v[8]  = mk(1, 0, 0, 0, 0, 1, 1, 4, 0);
        table_v[9]  = mk(1, 0, 0, 0, 0, 1, 1, 4, 0);
        table_v[10] = mk(1, 0, 0, 1, 1, 1, 1, 4, 0);
        table_v[11] = mk(1, 1, 1, 1, 0, 1, 1, 4, 1);  // N=1 rejected
        table_v[12] = mk(1, 0, 0, 0, 0, 1, 1, 4, 0);
        table_v[13] = mk(1, 0, 0, 0, 0, 1, 1, 4, 0);
        table_v[14] = mk(1, 1, 5, 1, 1, 0, 1, 4, 0);  // N=5 sent on boundary
        table_v[15] = mk(1, 0, 0, 1, 0, 0, 1, 4, 0);
        table_v[16] = mk(1, 0, 0, 0, 0, 0, 1, 4, 0);
        table_v[17] = mk(1, 0, 0, 0, 0, 0, 1, 4, 0);
        table_v[18] = mk(1, 0, 0, 1, 1, 1, 1, 5, 0);
        table_v[19] = mk(0, 0, 0, 1, 0, 1, 1, 5, 0);  // en dropped at cnt=0
        table_v[20] = mk(0, 0, 0, 1, 0, 1, 1, 5, 0);
        table_v[21] = mk(0, 0, 0, 0, 0, 1, 1, 5, 0);
        table_v[22] = mk(0, 0, 0, 0, 0, 1, 1, 5, 0);
        table_v[23] = mk(0, 0, 0, 0, 0, 1, 0, 5, 0);
        table_v[24] = mk(0, 0, 0, 0, 0, 1, 0, 5, 0);
        table_v[25] = mk(1, 0, 0, 1, 1, 1, 1, 5, 0);
        table_v[26] = mk(1, 0, 0, 1, 0, 1, 1, 5, 0);

        @(negedge clk_in);
        check("reset_values", mk_obs(0, 0, 1, 0, RST_DIV, 0));
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            en        = table_v[i].en;
            div_valid = table_v[i].valid;
            div_val   = table_v[i].val;
            @(posedge clk_in);
            @(negedge clk_in);
            check($sformatf("vec%0d", i), table_v[i].exp);
        end
        div_valid = 1'b0;

        // Asynchronous reset while N=4 is pending at cnt=1.
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        en  = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check("restart_cnt0", mk_obs(1, 1, 1, 1, 3, 0));
        div_valid = 1'b1;
        div_val   = W'(4);
        @(posedge clk_in);
        @(negedge clk_in);
        div_valid = 1'b0;
        check("pend_cnt1", mk_obs(1, 0, 0, 1, 3, 0));
        #2 rst = 1'b1;
        #1 check("rst_async_pend", mk_obs(0, 0, 1, 0, RST_DIV, 0));
        @(negedge clk_in);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            check($sformatf("post_rst%0d", k),
                  mk_obs((k % 3) < 2, (k % 3) == 0, 1, 1, RST_DIV, 0));
        end

        // Randomized traffic against the reference model.
        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        @(negedge clk_in);
        rst = 1'b0;
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(63) == 0);
            en        = ($urandom_range(7) != 0);
            div_valid = ($urandom_range(5) == 0);
            div_val   = W'($urandom_range(9));
            @(posedge clk_in);
            if (rst) model_reset();
            else model_step(en, div_valid, int'(div_val));
            @(negedge clk_in);
            check($sformatf("rand%0d", c), model_obs());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
